zap_copro_arbiter: RTL and testbench

ZAP_COPRO_ARBITER -- requirements
Module: zap_copro_arbiter

---
 rtl/zap_copro_arbiter_if.sv | 72 +++++++
 rtl/zap_copro_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_zap_copro_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/zap_copro_arbiter_if.sv
// ----------------------------------------------------------------------------
// zap_copro_arbiter_if
//
// Purpose : Groups the request/response handshake between the predecode stage,
//           the coprocessor arbiter and the two coprocessor ports (A and B).
//
// Signals :
//   i_copro_dav   core -> arbiter   request valid, held until done
//   i_copro_word  core -> arbiter   32-bit coprocessor instruction word
//   i_clear       core -> arbiter   pipeline flush, aborts any transaction
//   o_copro_done  arbiter -> core   one-cycle completion pulse
//   o_copro_und   arbiter -> core   one-cycle undefined pulse (with done)
//   o_busy        arbiter -> core   arbiter not idle
//   o_cpa_dav     arbiter -> CP A   request valid
//   o_cpa_word    arbiter -> CP A   latched instruction word
//   i_cpa_done    CP A -> arbiter   completion
//   o_cpb_dav     arbiter -> CP B   request valid
//   o_cpb_word    arbiter -> CP B   latched instruction word
//   i_cpb_done    CP B -> arbiter   completion
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (core plus coprocessors) driving the arbiter
// ----------------------------------------------------------------------------
interface zap_copro_arbiter_if;

    logic        i_copro_dav;
    logic [31:0] i_copro_word;
    logic        i_clear;
    logic        o_copro_done;
    logic        o_copro_und;
    logic        o_busy;

    logic        o_cpa_dav;
    logic [31:0] o_cpa_word;
    logic        i_cpa_done;

    logic        o_cpb_dav;
    logic [31:0] o_cpb_word;
    logic        i_cpb_done;

    modport slave (
        input  i_copro_dav,
        input  i_copro_word,
        input  i_clear,
        input  i_cpa_done,
        input  i_cpb_done,
        output o_copro_done,
        output o_copro_und,
        output o_busy,
        output o_cpa_dav,
        output o_cpa_word,
        output o_cpb_dav,
        output o_cpb_word
    );

    modport master (
        output i_copro_dav,
        output i_copro_word,
        output i_clear,
        output i_cpa_done,
        output i_cpb_done,
        input  o_copro_done,
        input  o_copro_und,
        input  o_busy,
        input  o_cpa_dav,
        input  o_cpa_word,
        input  o_cpb_dav,
        input  o_cpb_word
    );

endinterface

// File: rtl/zap_copro_arbiter.sv
// ----------------------------------------------------------------------------
// zap_copro_arbiter
//
// Purpose : Routes a coprocessor instruction from the predecode stage to one
//           of two coprocessor ports, selected by instruction bits [11:8].
//           Unmapped coprocessor numbers are answered immediately with an
//           undefined-instruction response. All outputs are registered.
//
//           FSM: IDLE -> WAIT (mapped) or RESP (unmapped)
//                WAIT -> RESP on completion from the selected port
//                RESP -> DRAIN (always, one cycle)
//                DRAIN -> IDLE once the core drops its request, so a request
//                         that is still held never starts a second transaction
//           A flush (i_clear) returns to IDLE from any state, silently.
//
// Ports   :
//   i_clk      core clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        zap_copro_arbiter_if.slave (request/response and both CP ports)
//
// Parameters:
//   CPA_NUM         coprocessor number served by port A (default 15)
//   CPB_NUM         coprocessor number served by port B (default 14)
//   TIMEOUT_CYCLES  WAIT-state cycle limit, 1..255 (default 255)
//
// Configuration:
//   `define ZAP_COPRO_TIMEOUT_EN adds an 8-bit WAIT cycle counter. After
//   TIMEOUT_CYCLES cycles in WAIT without completion the transaction ends
//   with done=1, und=1. Completion in the final cycle still counts as a
//   normal completion. Without the macro, WAIT persists until done or flush.
// ----------------------------------------------------------------------------
module zap_copro_arbiter #(
    parameter logic [3:0]  CPA_NUM        = 4'd15,
    parameter logic [3:0]  CPB_NUM        = 4'd14,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    zap_copro_arbiter_if.slave     bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("zap_copro_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic        sel_b_q, sel_b_d;       // 0: port A owns the transaction, 1: port B
    logic        cpa_dav_q, cpa_dav_d;
    logic        cpb_dav_q, cpb_dav_d;
    logic [31:0] cpa_word_q, cpa_word_d;
    logic [31:0] cpb_word_q, cpb_word_d;
    logic        done_q, done_d;
    logic        und_q, und_d;
    logic        busy_q, busy_d;

    logic        hit_a, hit_b;
    logic        sel_done;

`ifdef ZAP_COPRO_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
`endif

    // Port A wins if both parameters name the same coprocessor.
    assign hit_a    = (bus.i_copro_word[11:8] == CPA_NUM);
    assign hit_b    = (bus.i_copro_word[11:8] == CPB_NUM) && !hit_a;
    // Completion from the port that does not own the transaction is ignored.
    assign sel_done = sel_b_q ? bus.i_cpb_done : bus.i_cpa_done;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        sel_b_d    = sel_b_q;
        cpa_dav_d  = 1'b0;
        cpb_dav_d  = 1'b0;
        cpa_word_d = cpa_word_q;
        cpb_word_d = cpb_word_q;
        done_d     = 1'b0;
        und_d      = 1'b0;
`ifdef ZAP_COPRO_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.i_copro_dav) begin
                    if (hit_a) begin
                        sel_b_d    = 1'b0;
                        cpa_word_d = bus.i_copro_word;
                        cpa_dav_d  = 1'b1;
                        state_d    = S_WAIT;
`ifdef ZAP_COPRO_TIMEOUT_EN
                        tmo_cnt_d  = 8'd0;
`endif
                    end else if (hit_b) begin
                        sel_b_d    = 1'b1;
                        cpb_word_d = bus.i_copro_word;
                        cpb_dav_d  = 1'b1;
                        state_d    = S_WAIT;
`ifdef ZAP_COPRO_TIMEOUT_EN
                        tmo_cnt_d  = 8'd0;
`endif
                    end else begin
                        // Nobody serves this coprocessor: answer undefined.
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        und_d   = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (sel_done) begin
                    state_d = S_RESP;
                    done_d  = 1'b1;
                end
`ifdef ZAP_COPRO_TIMEOUT_EN
                // The count reaching the limit means this is the last WAIT cycle.
                else if ((tmo_cnt_q + 8'd1) == TMO_LIMIT) begin
                    state_d = S_RESP;
                    done_d  = 1'b1;
                    und_d   = 1'b1;
                end
`endif
                else begin
                    cpa_dav_d = !sel_b_q;
                    cpb_dav_d = sel_b_q;
`ifdef ZAP_COPRO_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
                end
            end

            S_RESP: begin
                state_d = S_DRAIN;
            end

            S_DRAIN: begin
                // The core holds dav until it sees done; wait for it to drop.
                if (!bus.i_copro_dav) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush overrides everything, including a completion or timeout
        // arriving in the same cycle, and leaves the word registers alone.
        if (bus.i_clear) begin
            state_d    = S_IDLE;
            sel_b_d    = sel_b_q;
            cpa_dav_d  = 1'b0;
            cpb_dav_d  = 1'b0;
            cpa_word_d = cpa_word_q;
            cpb_word_d = cpb_word_q;
            done_d     = 1'b0;
            und_d      = 1'b0;
`ifdef ZAP_COPRO_TIMEOUT_EN
            tmo_cnt_d  = 8'd0;
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            sel_b_q    <= 1'b0;
            cpa_dav_q  <= 1'b0;
            cpb_dav_q  <= 1'b0;
            // NOTE: the word registers are reset as well, so the coprocessor
            // ports never present X after reset.
            cpa_word_q <= 32'd0;
            cpb_word_q <= 32'd0;
            done_q     <= 1'b0;
            und_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef ZAP_COPRO_TIMEOUT_EN
            tmo_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            sel_b_q    <= sel_b_d;
            cpa_dav_q  <= cpa_dav_d;
            cpb_dav_q  <= cpb_dav_d;
            cpa_word_q <= cpa_word_d;
            cpb_word_q <= cpb_word_d;
            done_q     <= done_d;
            und_q      <= und_d;
            busy_q     <= busy_d;
`ifdef ZAP_COPRO_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    assign bus.o_cpa_dav    = cpa_dav_q;
    assign bus.o_cpb_dav    = cpb_dav_q;
    assign bus.o_cpa_word   = cpa_word_q;
    assign bus.o_cpb_word   = cpb_word_q;
    assign bus.o_copro_done = done_q;
    assign bus.o_copro_und  = und_q;
    assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_zap_copro_arbiter.sv
// ----------------------------------------------------------------------------
// tb_zap_copro_arbiter
//
// Self-checking bench for zap_copro_arbiter. The stimulus process pushes the
// expected response (cycle and und flag) for each request into a queue; a
// monitor on the falling edge pops and compares whenever o_copro_done is seen.
// Port levels are checked directly against hand-computed values.
// Cycle numbering: a request driven during cycle k is sampled at the edge
// that starts cycle k+1.
// ----------------------------------------------------------------------------
module tb_zap_copro_arbiter;

    localparam int TMO = 4;

    logic i_clk;
    logic i_reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        int   at_cyc;
        logic und;
    } resp_t;

    resp_t exp_q[$];

    zap_copro_arbiter_if bus ();

    zap_copro_arbiter #(
        .CPA_NUM        (4'd15),
        .CPB_NUM        (4'd14),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Response monitor / scoreboard.
    always @(negedge i_clk) begin
        if (bus.o_copro_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.at_cyc));
                check("done_und", {31'd0, bus.o_copro_und}, {31'd0, e.und});
            end
        end else if (bus.o_copro_und === 1'b1) begin
            failures++;
            $display("FAIL und_without_done: got und=1 done=%b expected und=0", bus.o_copro_done);
        end
        if (bus.o_cpa_dav === 1'b1 && bus.o_cpb_dav === 1'b1) begin
            failures++;
            $display("FAIL dav_exclusive: got cpa_dav=1 cpb_dav=1 expected at most one");
        end
    end

    initial begin
        #300us;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Bounded wait for all expected responses to be consumed.
    task automatic wait_sb();
        int budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic request(input logic [31:0] word, output int k);
        k = cyc;
        bus.i_copro_word = word;
        bus.i_copro_dav  = 1'b1;
    endtask

    initial begin
        int k;
        logic held_ok;

        bus.i_copro_dav  = 1'b0;
        bus.i_copro_word = 32'd0;
        bus.i_clear      = 1'b0;
        bus.i_cpa_done   = 1'b0;
        bus.i_cpb_done   = 1'b0;
        i_reset_n        = 1'b0;

        // ---------------- reset state ----------------
        #23;
        check("rst_cpa_dav",  {31'd0, bus.o_cpa_dav},  32'd0);
        check("rst_cpb_dav",  {31'd0, bus.o_cpb_dav},  32'd0);
        check("rst_done",     {31'd0, bus.o_copro_done}, 32'd0);
        check("rst_und",      {31'd0, bus.o_copro_und},  32'd0);
        check("rst_busy",     {31'd0, bus.o_busy},     32'd0);
        check("rst_cpa_word", bus.o_cpa_word, 32'd0);
        check("rst_cpb_word", bus.o_cpb_word, 32'd0);
        i_reset_n = 1'b1;
        tick(2);

        // ---------------- CP15 -> port A, done at cycle 5 ----------------
        request(32'hEE010F10, k);
        exp_q.push_back('{k + 6, 1'b0});
        tick();
        check("a_dav_rise",  {31'd0, bus.o_cpa_dav}, 32'd1);
        check("a_cpb_quiet", {31'd0, bus.o_cpb_dav}, 32'd0);
        check("a_word",      bus.o_cpa_word, 32'hEE010F10);
        check("a_busy",      {31'd0, bus.o_busy}, 32'd1);
        tick(4);                               // cycle k+5
        check("a_dav_c5",    {31'd0, bus.o_cpa_dav}, 32'd1);
        bus.i_cpa_done = 1'b1;
        tick();                                // cycle k+6
        bus.i_cpa_done  = 1'b0;
        bus.i_copro_dav = 1'b0;
        check("a_dav_fall",  {31'd0, bus.o_cpa_dav}, 32'd0);
        tick(2);                               // RESP -> DRAIN -> IDLE
        check("a_idle",      {31'd0, bus.o_busy}, 32'd0);
        check("a_word_hold", bus.o_cpa_word, 32'hEE010F10);
        wait_sb();

        // ---------------- CP14 -> port B, stray A done ignored ----------------
        request(32'hEE010E10, k);
        exp_q.push_back('{k + 4, 1'b0});
        tick();                                // k+1
        check("b_dav_rise",  {31'd0, bus.o_cpb_dav}, 32'd1);
        check("b_cpa_quiet", {31'd0, bus.o_cpa_dav}, 32'd0);
        check("b_word",      bus.o_cpb_word, 32'hEE010E10);
        check("b_a_word_hold", bus.o_cpa_word, 32'hEE010F10);
        bus.i_cpa_done = 1'b1;
        tick();                                // k+2
        bus.i_cpa_done = 1'b0;
        check("b_ignore_a_done", {31'd0, bus.o_cpb_dav}, 32'd1);
        tick();                                // k+3
        bus.i_cpb_done = 1'b1;
        tick();                                // k+4
        bus.i_cpb_done  = 1'b0;
        bus.i_copro_dav = 1'b0;
        check("b_dav_fall",  {31'd0, bus.o_cpb_dav}, 32'd0);
        tick(2);
        check("b_idle",      {31'd0, bus.o_busy}, 32'd0);
        wait_sb();

        // ---------------- CP5 unmapped, DRAIN holds ----------------
        request(32'hEE010510, k);
        exp_q.push_back('{k + 1, 1'b1});
        tick();                                // k+1
        check("u_no_cpa", {31'd0, bus.o_cpa_dav}, 32'd0);
        check("u_no_cpb", {31'd0, bus.o_cpb_dav}, 32'd0);
        tick(4);                               // dav still held
        check("u_drain_busy", {31'd0, bus.o_busy}, 32'd1);
        check("u_a_word", bus.o_cpa_word, 32'hEE010F10);
        check("u_b_word", bus.o_cpb_word, 32'hEE010E10);
        bus.i_copro_dav = 1'b0;
        tick();
        check("u_idle", {31'd0, bus.o_busy}, 32'd0);
        wait_sb();

        // ---------------- clear coincident with done in WAIT ----------------
        request(32'hEE011F30, k);
        tick();
        check("c_dav_rise", {31'd0, bus.o_cpa_dav}, 32'd1);
        tick();
        bus.i_clear     = 1'b1;
        bus.i_cpa_done  = 1'b1;
        bus.i_copro_dav = 1'b0;
        tick();
        bus.i_clear    = 1'b0;
        bus.i_cpa_done = 1'b0;
        check("c_dav_drop", {31'd0, bus.o_cpa_dav}, 32'd0);
        check("c_idle",     {31'd0, bus.o_busy}, 32'd0);
        check("c_word_hold", bus.o_cpa_word, 32'hEE011F30);
        tick(3);
        wait_sb();

`ifdef ZAP_COPRO_TIMEOUT_EN
        // ---------------- timeout after TMO WAIT cycles ----------------
        request(32'hEE010E10, k);
        exp_q.push_back('{k + TMO + 1, 1'b1});
        tick(TMO);
        check("t_dav_last", {31'd0, bus.o_cpb_dav}, 32'd1);
        tick();
        bus.i_copro_dav = 1'b0;
        check("t_dav_drop", {31'd0, bus.o_cpb_dav}, 32'd0);
        tick(2);
        wait_sb();

        // ---------------- done and timeout together -> done ----------------
        request(32'hEE010F10, k);
        exp_q.push_back('{k + TMO + 1, 1'b0});
        tick(TMO);
        bus.i_cpa_done = 1'b1;
        tick();
        bus.i_cpa_done  = 1'b0;
        bus.i_copro_dav = 1'b0;
        check("td_dav_drop", {31'd0, bus.o_cpa_dav}, 32'd0);
        tick(2);
        wait_sb();
`else
        // ---------------- no timeout: WAIT held 1000 cycles ----------------
        request(32'hEE010E10, k);
        held_ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.o_cpb_dav !== 1'b1) held_ok = 1'b0;
        end
        check("nt_wait_held", {31'd0, held_ok}, 32'd1);
        bus.i_clear     = 1'b1;
        bus.i_copro_dav = 1'b0;
        tick();
        bus.i_clear = 1'b0;
        check("nt_clear_idle", {31'd0, bus.o_busy}, 32'd0);
        tick(2);
        wait_sb();
`endif

        // ---------------- async reset mid-WAIT ----------------
        request(32'hEE010F10, k);
        tick(2);
        check("r_dav_before", {31'd0, bus.o_cpa_dav}, 32'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("r_cpa_dav",  {31'd0, bus.o_cpa_dav},  32'd0);
        check("r_busy",     {31'd0, bus.o_busy},     32'd0);
        check("r_done",     {31'd0, bus.o_copro_done}, 32'd0);
        check("r_cpa_word", bus.o_cpa_word, 32'd0);
        check("r_cpb_word", bus.o_cpb_word, 32'd0);
        bus.i_copro_dav = 1'b0;
        tick();
        #2;
        i_reset_n = 1'b1;
        tick();
        request(32'hEE010E10, k);
        exp_q.push_back('{k + 2, 1'b0});
        tick();
        check("r2_dav_rise", {31'd0, bus.o_cpb_dav}, 32'd1);
        bus.i_cpb_done = 1'b1;
        tick();
        bus.i_cpb_done  = 1'b0;
        bus.i_copro_dav = 1'b0;
        tick(2);
        check("r2_idle", {31'd0, bus.o_busy}, 32'd0);
        wait_sb();

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
